// File: rtl/mips_mem_loader_if.sv
// mips_mem_loader_if: byte-stream input and BRAM write-port bundle for the memory image loader
//   in_valid/in_data/in_ready : byte stream, transfer on in_valid && in_ready
//   mem_wen/mem_addr/mem_wdata : word write port into the CPU BRAM
//   master = loader side, slave = stream source / BRAM side
interface mips_mem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    modport master (input in_valid, in_data, output in_ready, mem_wen, mem_addr, mem_wdata);
    modport slave (output in_valid, in_data, input in_ready, mem_wen, mem_addr, mem_wdata);
endinterface

// File: rtl/mips_mem_loader.sv
// mips_mem_loader: loads a length/words/XOR-checksum byte stream into BRAM, holding the CPU in reset until verified
//   mips_cpu_clk, mips_cpu_reset : clock, async active-high reset
//   bus           : stream input and BRAM write port (mips_mem_loader_if.master)
//   cpu_reset_out : CPU core reset, released only after a verified load
//   load_done     : image loaded and checksum matched (sticky)
//   load_error    : length overflow or checksum mismatch (sticky)
//   words_loaded  : words written so far
module mips_mem_loader #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  mips_cpu_clk,
    input  logic                  mips_cpu_reset,
    mips_mem_loader_if.master     bus,
    output logic                  cpu_reset_out,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam logic [2:0] HDR  = 3'd0;
    localparam logic [2:0] DATA = 3'd1;
    localparam logic [2:0] CHK  = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;
    localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;

    logic [2:0]            state, nxt;
    logic [1:0]            bcnt;
    logic [23:0]           part;
    logic [31:0]           word, csum;
    logic [ADDR_WIDTH:0]   idx, idx_inc, n_words;
    logic                  fire, last;

    assign words_loaded = idx;

    // word is the field being completed by the current byte: earlier bytes sit in part, newest byte on top
    always_comb begin
        fire    = bus.in_valid && bus.in_ready;
        last    = fire && bcnt == 2'd3;
        word    = {bus.in_data, part};
        idx_inc = idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
        nxt     = !last           ? state :
                  state == HDR    ? ({1'b0, word} > CAP ? ERR : word == '0 ? CHK : DATA) :
                  state == DATA   ? (idx_inc == n_words ? CHK : DATA) :
                  state == CHK    ? (word == csum ? DONE : ERR) : state;
    end

    always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
        if (mips_cpu_reset) begin
            state         <= HDR;
            bcnt          <= '0;
            part          <= '0;
            csum          <= '0;
            idx           <= '0;
            n_words       <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_wen   <= 1'b0;
            bus.mem_addr  <= BASE_ADDR;
            bus.mem_wdata <= '0;
            cpu_reset_out <= 1'b1;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
        end else begin
            state         <= nxt;
            bus.in_ready  <= nxt == HDR || nxt == DATA || nxt == CHK;
            bus.mem_wen   <= last && state == DATA;
            cpu_reset_out <= nxt != DONE;
            load_done     <= nxt == DONE;
            load_error    <= nxt == ERR;
            if (fire) begin
                bcnt <= bcnt + 2'd1;
                part <= {bus.in_data, part[23:8]};
            end
            // n_words is only consulted when the header passed the capacity check, so truncation is safe
            if (last && state == HDR)
                n_words <= word[ADDR_WIDTH:0];
            if (last && state == DATA) begin
                bus.mem_addr  <= BASE_ADDR + 32'({idx, 2'b00});
                bus.mem_wdata <= word;
                csum          <= csum ^ word;
                idx           <= idx_inc;
            end
        end
    end
endmodule
